motor_pwm_driver: RTL
=====================

// Module: motor_pwm_driver
// PURPOSE
//  Consumes the motorLeft/motorRight on/off commands produced by the line-follower
//  controller and drives the two H-bridge enable pins with PWM.
//  Each channel soft-starts by ramping duty up to DUTY_MAX and soft-stops by ramping it
//  down to 0, which limits inrush current and wheel slip.
//  Sits between the controller FSM and the board motor pins; all logic is on one clock.
// PARAMETERS
//  CNT_W     8    PWM counter width; PWM period = 2**CNT_W clocks
//  STEP      8    duty increment/decrement applied per ramp tick
//  RAMP_DIV  64   clocks per ramp tick; must be >= 1
//  DUTY_MAX  240  RUN duty ceiling; must be <= 2**CNT_W-1
// PORTS
//  clk        in   1      system clock, rising edge
//  reset_n    in   1      asynchronous reset, active-low
//  motorLeft  in   1      left motor command (1 = run); synchronous to clk
//  motorRight in   1      right motor command (1 = run); synchronous to clk
//  pwmLeft    out  1      left H-bridge enable, PWM
//  pwmRight   out  1      right H-bridge enable, PWM
//  dutyLeft   out  CNT_W  left duty currently applied to the comparator
//  dutyRight  out  CNT_W  right duty currently applied to the comparator
//  busy       out  1      1 while either channel is in RAMP_UP or RAMP_DOWN
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous): pwm*=0, duty*=0, busy=0, PWM counter=0, prescaler=0,
//    both channels IDLE. Reset asserted mid-ramp aborts the ramp immediately; no ramp-down.
//  - PWM counter: free-running modulo 2**CNT_W. Shared by both channels.
//  - Ramp prescaler: counts 0..RAMP_DIV-1; tick=1 for one clock when it wraps.
//  - Commands are registered once; the FSM reacts one clock after an input edge.
//  - Per-channel FSM, with target duty `tgt`:
//      IDLE      cmd=1 -> RAMP_UP
//      RAMP_UP   on tick: tgt=min(tgt+STEP,DUTY_MAX); reaching DUTY_MAX -> RUN;
//                cmd=0 -> RAMP_DOWN, starting from the current tgt
//      RUN       cmd=0 -> RAMP_DOWN
//      RAMP_DOWN on tick: tgt=max(tgt-STEP,0), clamped at 0 with no wrap;
//                reaching 0 -> IDLE; cmd=1 -> RAMP_UP from the current tgt
//  - Arithmetic: compute add/sub in CNT_W+1 bits, then saturate. tgt never exceeds DUTY_MAX.
//  - If a ramp tick and a command reversal occur in the same cycle, the direction change wins.
//    tgt is not stepped in that cycle.
//  - Glitch-free update: duty* latches tgt only in the cycle the PWM counter == 2**CNT_W-1,
//    so a new duty takes effect at the start of the next period.
//  - pwm* = registered (counter < duty*). duty=0 gives constant 0.
//    duty=N gives N high clocks per period.
//  - busy = OR of both channels' RAMP states, registered.
//  - Both channels are independent. Simultaneous commands on both are handled in parallel.
// STRUCTURE
//  - Package motor_pwm_pkg holds the channel state encoding
//    (IDLE=2'd0, RAMP_UP=2'd1, RUN=2'd2, RAMP_DOWN=2'd3).
//  - Top level: PWM counter, ramp prescaler, busy OR.
//  - Sub-module motor_ramp_channel (FSM, tgt register, duty latch, comparator), instantiated
//    twice. Inputs: cmd, tick, cnt_wrap, cnt. Outputs: pwm, duty, ramping.
// TESTING (bench parameters: CNT_W=4, STEP=4, RAMP_DIV=2, DUTY_MAX=14; 10 ns clock)
//  1. Reset: hold reset_n=0 while toggling motor* -> pwm*=0, duty*=0, busy=0.
//     Asserting reset_n mid-period clears outputs without waiting for a clock edge.
//  2. Soft start: motorLeft=1 -> tgt steps 4,8,12,14 on 4 ticks and reaches RUN;
//     busy=1 throughout the ramp.
//     dutyLeft changes only at counter wrap and ends at 14 (14 high / 2 low per 16 clocks).
//     Right channel stays 0.
//  3. Soft stop: from RUN, motorLeft=0 -> tgt 10,6,2,0 -> IDLE; pwmLeft is constantly 0.
//     busy drops after IDLE is reached.
//  4. Reversal: motorRight=1 until tgt=8, then 0 -> descends 4,0 without first reaching 14.
//     Repeat with a reversal on a tick cycle: tgt is not stepped in that cycle.
//  5. Both channels: motorLeft=motorRight=1 in the same cycle -> dutyLeft==dutyRight
//     every cycle, and pwm* match.
//  6. Reset mid-ramp: reset_n=0 while tgt=8 -> immediately IDLE with duty 0.
//     After release with cmd=1, the ramp restarts from 0.

Source files
------------

// File: rtl/motor_pwm_pkg.sv
// rtl/motor_pwm_pkg.sv - channel state encoding shared by the motor PWM driver
package motor_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } chan_state_t;

  function automatic logic is_ramping(input chan_state_t s);
    return (s == ST_RAMP_UP) || (s == ST_RAMP_DOWN);
  endfunction

endpackage

// File: rtl/motor_ramp_channel.sv
// rtl/motor_ramp_channel.sv - one motor channel: soft-start/stop FSM, duty latch, PWM comparator
module motor_ramp_channel #(
  parameter int CNT_W    = 8,
  parameter int STEP     = 8,
  parameter int DUTY_MAX = 240
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd,
  input  logic             tick,
  input  logic             cnt_wrap,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm,
  output logic [CNT_W-1:0] duty,
  output logic             ramping
);
  import motor_pwm_pkg::*;

  localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);
  localparam logic [CNT_W:0]   MAX_X  = (CNT_W+1)'(DUTY_MAX);
  localparam logic [CNT_W-1:0] MAX_N  = CNT_W'(DUTY_MAX);

  logic             cmd_q;
  chan_state_t      state, state_nxt;
  logic [CNT_W-1:0] tgt, tgt_nxt, up_sat, dn_sat;
  logic [CNT_W:0]   sum, diff;

  // One extra bit so overflow and borrow are visible before saturating
  assign sum    = {1'b0, tgt} + STEP_X;
  assign diff   = {1'b0, tgt} - STEP_X;
  assign up_sat = (sum >= MAX_X) ? MAX_N : sum[CNT_W-1:0];
  assign dn_sat = diff[CNT_W] ? '0 : diff[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= 1'b0;
      state <= ST_IDLE;
      tgt   <= '0;
    end else begin
      cmd_q <= cmd;
      state <= state_nxt;
      tgt   <= tgt_nxt;
    end
  end

  // A direction change takes priority over a coincident ramp tick
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    case (state)
      ST_IDLE: if (cmd_q) state_nxt = ST_RAMP_UP;
      ST_RAMP_UP: begin
        if (!cmd_q) begin
          state_nxt = ST_RAMP_DOWN;
        end else if (tick) begin
          tgt_nxt = up_sat;
          if (up_sat == MAX_N) state_nxt = ST_RUN;
        end
      end
      ST_RUN: if (!cmd_q) state_nxt = ST_RAMP_DOWN;
      ST_RAMP_DOWN: begin
        if (cmd_q) begin
          state_nxt = ST_RAMP_UP;
        end else if (tick) begin
          tgt_nxt = dn_sat;
          if (dn_sat == '0) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ramping = is_ramping(state);
  end

  // Duty only changes at the period boundary so no pulse is ever truncated
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      if (cnt_wrap) duty <= tgt;
      pwm <= (cnt < duty);
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - two-channel soft-start PWM driver for the H-bridge enables
module motor_pwm_driver #(
  parameter int CNT_W    = 8,
  parameter int STEP     = 8,
  parameter int RAMP_DIV = 64,
  parameter int DUTY_MAX = 240
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             motorLeft,
  input  logic             motorRight,
  output logic             pwmLeft,
  output logic             pwmRight,
  output logic [CNT_W-1:0] dutyLeft,
  output logic [CNT_W-1:0] dutyRight,
  output logic             busy
);
  import motor_pwm_pkg::*;

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [PRE_W-1:0] pre;
  logic             tick, cnt_wrap, ramp_left, ramp_right;

  assign tick     = (pre == PRE_W'(RAMP_DIV - 1));
  assign cnt_wrap = (cnt == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      pre  <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      pre  <= tick ? '0 : pre + 1'b1;
      busy <= ramp_left | ramp_right;
    end
  end

  motor_ramp_channel #(.CNT_W(CNT_W), .STEP(STEP), .DUTY_MAX(DUTY_MAX)) u_left (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd      (motorLeft),
    .tick     (tick),
    .cnt_wrap (cnt_wrap),
    .cnt      (cnt),
    .pwm      (pwmLeft),
    .duty     (dutyLeft),
    .ramping  (ramp_left)
  );

  motor_ramp_channel #(.CNT_W(CNT_W), .STEP(STEP), .DUTY_MAX(DUTY_MAX)) u_right (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd      (motorRight),
    .tick     (tick),
    .cnt_wrap (cnt_wrap),
    .cnt      (cnt),
    .pwm      (pwmRight),
    .duty     (dutyRight),
    .ramping  (ramp_right)
  );

endmodule
